warp_mem_responder: RTL and testbench

- Memory-side responder for the lane memory request/response protocol: accepts one request per cycle, services it from an internal word-addressed SRAM, returns exactly one response per request, in order.
- Used as the scratchpad/backing-memory model behind the Warp lane memory initiator, in simulation and in FPGA builds.
- Fixed-latency read pipeline feeds a response queue, so the response channel can be backpressured.

---
 rtl/warp_pkg.sv | 15 +
 rtl/warp_mem_responder_if.sv | 27 ++
 rtl/warp_sync_fifo.sv | 51 +++++
 rtl/warp_mem_responder.sv | 113 +++++++++++
 tb/tb_warp_mem_responder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/warp_pkg.sv
// Shared Warp types and defaults for the lane memory request/response protocol.
package warp_pkg;

    localparam int unsigned DATA_WIDTH             = 32;
    localparam int unsigned ADDR_WIDTH             = 32;
    localparam int unsigned MEM_RESP_DEPTH_DEFAULT = 4;
    localparam int unsigned MEM_LATENCY_DEFAULT    = 2;

    // Response payload; err sits in the LSB so {data, err} packs the same way.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
    } mem_resp_t;

endpackage

// File: rtl/warp_mem_responder_if.sv
// Lane memory request/response channel between an initiator and a responder.
interface warp_mem_responder_if #(
    parameter int unsigned ADDR_WIDTH = warp_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = warp_pkg::DATA_WIDTH
);

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_write;
    logic [DATA_WIDTH-1:0] mem_req_data;
    logic                  mem_resp_valid;
    logic                  mem_resp_ready;
    logic [DATA_WIDTH-1:0] mem_resp_data;
    logic                  mem_resp_err;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_write, mem_req_data, mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_data, mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
    );

endinterface

// File: rtl/warp_sync_fifo.sv
// Show-ahead synchronous FIFO; push and pop may coincide at any occupancy.
module warp_sync_fifo #(
    parameter  int unsigned WIDTH = 33,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign dout  = store[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/warp_mem_responder.sv
// Word-addressed SRAM responder: fixed-latency pipeline into a response queue.
module warp_mem_responder #(
    parameter int unsigned DATA_WIDTH = warp_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = warp_pkg::ADDR_WIDTH,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned LATENCY    = warp_pkg::MEM_LATENCY_DEFAULT,
    parameter int unsigned RESP_DEPTH = warp_pkg::MEM_RESP_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    warp_mem_responder_if.slave mem,
    output logic                busy
);

    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam int unsigned ENT_W  = DATA_WIDTH + 1;
    localparam int unsigned FCNT_W = $clog2(RESP_DEPTH) + 1;
    localparam int unsigned CNT_W  = $clog2(RESP_DEPTH + LATENCY) + 1;
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

    logic                  accept;
    logic                  pop;
    logic                  push;
    logic                  addr_err;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] in_data;
    logic [ENT_W-1:0]      in_entry;
    logic [ENT_W-1:0]      push_entry;
    logic [ENT_W-1:0]      head;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      used;
    logic [FCNT_W-1:0]     fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] sram [MEM_DEPTH];

    // Decode: full-width range compare so high address bits cannot alias.
    assign idx      = mem.mem_req_addr[IDX_W+1:2];
    assign addr_err = (mem.mem_req_addr[1:0] != 2'b00) || (mem.mem_req_addr >= MEM_BYTES);
    assign accept   = mem.mem_req_valid && mem.mem_req_ready;
    assign rd_data  = sram[idx];
    assign in_data  = addr_err ? '0 : (mem.mem_req_write ? mem.mem_req_data : rd_data);
    assign in_entry = {in_data, addr_err};

    // SRAM write in the acceptance cycle; not reset so stores survive rst.
    always_ff @(posedge clk) begin
        if (accept && mem.mem_req_write && !addr_err) begin
            sram[idx] <= mem.mem_req_data;
        end
    end

    // The acceptance cycle counts as the first latency stage, so LATENCY-1
    // registered stages precede the queue push.
    if (LATENCY > 1) begin : g_pipe
        logic [LATENCY-2:0] pv;
        logic [ENT_W-1:0]   pd [LATENCY-1];

        // Valid bits and in-flight counter; cleared on reset to drop requests.
        always_ff @(posedge clk) begin
            if (rst) begin
                pv       <= '0;
                inflight <= '0;
            end else begin
                pv       <= {pv, accept};
                inflight <= inflight + CNT_W'(accept) - CNT_W'(pv[LATENCY-2]);
            end
        end

        // Payload shift register.
        always_ff @(posedge clk) begin
            pd[0] <= in_entry;
            for (int k = 1; k < int'(LATENCY) - 1; k++) begin
                pd[k] <= pd[k-1];
            end
        end

        assign push       = pv[LATENCY-2];
        assign push_entry = pd[LATENCY-2];
    end else begin : g_nopipe
        assign push       = accept;
        assign push_entry = in_entry;
        assign inflight   = '0;
    end

    warp_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_q (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Credit check uses registered occupancy only, so the queue cannot overflow.
    assign used              = inflight + CNT_W'(fifo_count);
    assign mem.mem_req_ready = !rst && !fifo_full && (used < CNT_W'(RESP_DEPTH));

    // Queue head drives the response channel; data reads zero when idle.
    assign mem.mem_resp_valid = !fifo_empty;
    assign mem.mem_resp_data  = fifo_empty ? '0 : head[ENT_W-1:1];
    assign mem.mem_resp_err   = !fifo_empty && head[0];
    assign pop                = mem.mem_resp_valid && mem.mem_resp_ready;

    assign busy = (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_warp_mem_responder.sv
// Directed and randomised checks for warp_mem_responder with a scoreboard model.
module tb_warp_mem_responder;
    import warp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    warp_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

    warp_mem_responder dut (
        .clk  (clk),
        .rst  (rst),
        .mem  (mem_if),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] model_mem [1024];
    mem_resp_t   sb [$];
    mem_resp_t   resp_log [$];

    logic        obs_rdy, obs_valid, obs_err, obs_busy, acc;
    logic [31:0] obs_data;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model of one accepted request.
    task automatic model_accept(input logic w, input logic [31:0] a, input logic [31:0] d);
        mem_resp_t e;
        logic      bad;
        bad    = (a[1:0] != 2'b00) || (a >= 32'h1000);
        e.err  = bad;
        e.data = bad ? 32'h0 : (w ? d : model_mem[a[11:2]]);
        if (w && !bad) model_mem[a[11:2]] = d;
        sb.push_back(e);
    endtask

    // One cycle: drive at the falling edge, observe outputs, score handshakes.
    task automatic step(input logic v, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic rr);
        mem_resp_t e;
        mem_resp_t g;
        @(negedge clk);
        mem_if.mem_req_valid  = v;
        mem_if.mem_req_write  = w;
        mem_if.mem_req_addr   = a;
        mem_if.mem_req_data   = d;
        mem_if.mem_resp_ready = rr;
        obs_rdy   = mem_if.mem_req_ready;
        obs_valid = mem_if.mem_resp_valid;
        obs_data  = mem_if.mem_resp_data;
        obs_err   = mem_if.mem_resp_err;
        obs_busy  = busy;
        acc       = v && obs_rdy;
        if (obs_valid && rr) begin
            g.data = obs_data;
            g.err  = obs_err;
            resp_log.push_back(g);
            if (sb.size() == 0) begin
                check_eq("unexpected_resp", 32'(obs_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                check_eq("resp_data", obs_data, e.data);
                check_eq("resp_err", 32'(obs_err), 32'(e.err));
            end
        end
        if (acc) model_accept(w, a, d);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 40) begin
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            n++;
        end
        check_eq("drain_bound", 32'(n < 40), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_mis=%0d", n_mis);
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int r;
        logic [31:0] a;
        mem_if.mem_req_valid  = 1'b0;
        mem_if.mem_req_write  = 1'b0;
        mem_if.mem_req_addr   = '0;
        mem_if.mem_req_data   = '0;
        mem_if.mem_resp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready_low", 32'(mem_if.mem_req_ready), 32'h0);
        rst = 1'b0;
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("post_rst_ready", 32'(obs_rdy), 32'h1);
        check_eq("post_rst_valid", 32'(obs_valid), 32'h0);
        check_eq("post_rst_data", obs_data, 32'h0);
        check_eq("post_rst_err", 32'(obs_err), 32'h0);
        check_eq("post_rst_busy", 32'(obs_busy), 32'h0);

        // Store then load same word; first response exactly LATENCY cycles later
        step(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        check_eq("lat_early", 32'(obs_valid), 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("lat_valid", 32'(obs_valid), 32'h1);
        check_eq("echo_data", obs_data, 32'hDEADBEEF);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("raw_valid", 32'(obs_valid), 32'h1);
        check_eq("raw_data", obs_data, 32'hDEADBEEF);
        check_eq("raw_err", 32'(obs_err), 32'h0);
        drain();

        // Faulty addresses
        resp_log.delete();
        step(1'b1, 1'b1, 32'h0,    32'hA5A5A5A5, 1'b1);
        step(1'b1, 1'b0, 32'h13,   32'h0,        1'b1);
        step(1'b1, 1'b0, 32'h1000, 32'h0,        1'b1);
        step(1'b1, 1'b1, 32'h1000, 32'h12345678, 1'b1);
        step(1'b1, 1'b0, 32'h0,    32'h0,        1'b1);
        step(1'b1, 1'b0, 32'h10,   32'h0,        1'b1);
        drain();
        check_eq("err_count", 32'(resp_log.size()), 32'd6);
        if (resp_log.size() == 6) begin
            check_eq("misalign_err",  32'(resp_log[1].err), 32'h1);
            check_eq("misalign_data", resp_log[1].data, 32'h0);
            check_eq("oor_err",       32'(resp_log[2].err), 32'h1);
            check_eq("oor_data",      resp_log[2].data, 32'h0);
            check_eq("oor_store_err", 32'(resp_log[3].err), 32'h1);
            check_eq("alias_word0",   resp_log[4].data, 32'hA5A5A5A5);
            check_eq("word4_intact",  resp_log[5].data, 32'hDEADBEEF);
        end

        // Prefill words 0..15 with i*3
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 32'(i * 4), 32'(i * 3), 1'b1);
        drain();

        // Backpressure: credit limits acceptance to the queue depth
        nxt = 0;
        for (int c = 0; c < 8; c++) begin
            step(nxt < 6, 1'b0, 32'((nxt + 1) * 4), 32'h0, 1'b0);
            if (acc) nxt++;
            if (obs_valid) check_eq("bp_head_stable", obs_data, 32'd3);
        end
        check_eq("bp_accepted", 32'(nxt), 32'd4);
        check_eq("bp_ready_low", 32'(obs_rdy), 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("bp_first_pop", obs_data, 32'd3);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("bp_ready_back", 32'(obs_rdy), 32'h1);
        drain();

        // Steady stream: one response per cycle, busy falls LATENCY+1 after last accept
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b1);
            check_eq("stream_ready", 32'(obs_rdy), 32'h1);
            if (i >= 2) check_eq("stream_valid", 32'(obs_valid), 32'h1);
        end
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("stream_busy_t1", 32'(obs_busy), 32'h1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("stream_busy_t2", 32'(obs_busy), 32'h1);
        check_eq("stream_last", obs_data, 32'd45);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check_eq("stream_busy_t3", 32'(obs_busy), 32'h0);
        check_eq("stream_sb_empty", 32'(sb.size()), 32'h0);

        // Reset mid-operation drops responses but keeps committed stores
        step(1'b1, 1'b1, 32'h50, 32'hCAFEF00D, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0);
        @(negedge clk);
        mem_if.mem_req_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check_eq("midrst_valid", 32'(mem_if.mem_resp_valid), 32'h0);
        check_eq("midrst_busy", 32'(busy), 32'h0);
        check_eq("midrst_ready", 32'(mem_if.mem_req_ready), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            check_eq("no_stale_resp", 32'(obs_valid), 32'h0);
        end
        resp_log.delete();
        step(1'b1, 1'b0, 32'h50, 32'h0, 1'b1);
        drain();
        check_eq("store_survives_rst", (resp_log.size() == 1) ? resp_log[0].data : 32'hX,
                 32'hCAFEF00D);

        // Random traffic against the scoreboard
        for (int c = 0; c < 1000; c++) begin
            r = $urandom_range(0, 19);
            case (r)
                16:      a = 32'h13;
                17:      a = 32'h1000;
                18:      a = 32'hFFFFFFFC;
                19:      a = 32'h3E;
                default: a = 32'(r * 4);
            endcase
            step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, a, $urandom,
                 $urandom_range(0, 9) < 6);
        end
        drain();
        check_eq("rand_sb_empty", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
